// File: rtl/fp_round_pkg.sv
// Shared types and encoding helpers for the IEEE-754 rounding/packing pipeline.
// Rounding-mode enum, exception-flag struct and saturation encodings sized per (M, E).
package fp_round_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    typedef struct packed {
        logic of;
        logic uf;
        logic nx;
    } fp_flags_t;

    // Encodings are built at a fixed generous width; callers keep the low 1+E+M bits.
    localparam int ENC_W = 64;

    // Reserved encodings 5..7 fall back to round-to-nearest-even.
    function automatic rm_e decode_rm(input logic [2:0] rm);
        rm_e mode;
        case (rm)
            3'd1:    mode = RM_RTZ;
            3'd2:    mode = RM_RDN;
            3'd3:    mode = RM_RUP;
            3'd4:    mode = RM_RMM;
            default: mode = RM_RNE;
        endcase
        return mode;
    endfunction

    function automatic logic [ENC_W-1:0] inf_enc(input int m, input int e, input logic sign);
        logic [ENC_W-1:0] v;
        v = ((64'd1 << e) - 64'd1) << m;
        v = v | ({{(ENC_W-1){1'b0}}, sign} << (m + e));
        return v;
    endfunction

    function automatic logic [ENC_W-1:0] max_finite_enc(input int m, input int e, input logic sign);
        logic [ENC_W-1:0] v;
        v = ((64'd1 << e) - 64'd2) << m;
        v = v | ((64'd1 << m) - 64'd1);
        v = v | ({{(ENC_W-1){1'b0}}, sign} << (m + e));
        return v;
    endfunction

endpackage

// File: rtl/fp_round_pipe_if.sv
// Upstream/downstream valid-ready bundle for fp_round_pipe.
// master = producer/consumer side (bench or neighbouring stages), slave = the rounding pipe.
interface fp_round_pipe_if #(
    parameter int M = 23,
    parameter int E = 8
);
    logic         in_valid;
    logic         in_ready;
    logic         sign_in;
    logic [M:0]   mant_in;
    logic [E:0]   exp_in;
    logic         guard;
    logic         round_bit;
    logic         sticky;
    logic [2:0]   rm;
    logic         out_valid;
    logic         out_ready;
    logic [E+M:0] result;
    logic         of_flag;
    logic         uf_flag;
    logic         nx_flag;

    modport master (
        output in_valid, sign_in, mant_in, exp_in, guard, round_bit, sticky, rm, out_ready,
        input  in_ready, out_valid, result, of_flag, uf_flag, nx_flag
    );

    modport slave (
        input  in_valid, sign_in, mant_in, exp_in, guard, round_bit, sticky, rm, out_ready,
        output in_ready, out_valid, result, of_flag, uf_flag, nx_flag
    );
endinterface

// File: rtl/fp_round_core.sv
// Combinational increment / renormalise / overflow-saturate / pack for a rounded significand.
// Shared between the rounding pipe's second stage and the FMA path.
module fp_round_core
    import fp_round_pkg::*;
#(
    parameter int M = 23,
    parameter int E = 8
) (
    input  logic         sign,
    input  logic [M:0]   mant,
    input  logic [E:0]   exp,
    input  logic         round_up,
    input  logic         inx,
    input  rm_e          rm,
    output logic [E+M:0] result,
    output fp_flags_t    flags
);
    localparam int W = 1 + E + M;
    localparam logic [E+1:0] EXP_SAT = {2'b00, {E{1'b1}}};

    logic [M+1:0]     sum;
    logic [E+1:0]     exp_r;
    logic [M-1:0]     frac;
    logic             of;
    logic             use_inf;
    logic [ENC_W-1:0] sat_v;
    logic             unused_sat_hi;

    always_comb begin
        // NOTE: every variable gets a default at the top of always_comb so no path
        // leaves it unassigned; that is what keeps this block free of inferred latches.
        sum   = {1'b0, mant} + {{(M+1){1'b0}}, round_up};
        frac  = sum[M-1:0];
        exp_r = {1'b0, exp};

        if (sum[M+1]) begin
            // Carry-out means the significand became exactly 2.0: shifted fraction is zero.
            frac  = '0;
            exp_r = {1'b0, exp} + {{(E+1){1'b0}}, 1'b1};
        end else if (exp == '0 && sum[M]) begin
            exp_r = {{(E+1){1'b0}}, 1'b1};
        end

        of = (exp_r >= EXP_SAT);

        case (rm)
            RM_RTZ:  use_inf = 1'b0;
            RM_RDN:  use_inf = sign;
            RM_RUP:  use_inf = !sign;
            default: use_inf = 1'b1;
        endcase

        sat_v = use_inf ? inf_enc(M, E, sign) : max_finite_enc(M, E, sign);

        result = {sign, exp_r[E-1:0], frac};
        if (of) begin
            result = sat_v[W-1:0];
        end

        flags.of = of;
        flags.uf = (exp == '0) & inx;
        flags.nx = inx | of;
    end

    assign unused_sat_hi = ^sat_v[ENC_W-1:W];

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage IEEE-754 round-and-pack pipe: S1 registers operands plus the round-up decision,
// S2 registers the packed result and flags. Optional macro FP_ROUND_ACCUM_FLAGS_EN adds sticky fflags.
module fp_round_pipe
    import fp_round_pkg::*;
#(
    parameter int M = 23,
    parameter int E = 8
) (
    input  logic              clk,
    input  logic              rst,
    fp_round_pipe_if.slave    bus
`ifdef FP_ROUND_ACCUM_FLAGS_EN
    ,
    input  logic              flags_clr,
    output logic [2:0]        fflags_acc
`endif
);
    localparam int W = 1 + E + M;

    logic         s2_adv;
    logic         s1_adv;
    logic         in_inx;
    logic         in_round_up;
    rm_e          in_rm;

    logic         s1_valid_q,    s1_valid_d;
    logic         s1_sign_q,     s1_sign_d;
    logic [M:0]   s1_mant_q,     s1_mant_d;
    logic [E:0]   s1_exp_q,      s1_exp_d;
    rm_e          s1_rm_q,       s1_rm_d;
    logic         s1_round_up_q, s1_round_up_d;
    logic         s1_inx_q,      s1_inx_d;

    logic         s2_valid_q,    s2_valid_d;
    logic [W-1:0] result_q,      result_d;
    fp_flags_t    flags_q,       flags_d;

    logic [W-1:0] core_result;
    fp_flags_t    core_flags;

    // Stage 1: round-up decision from the raw operand bits.
    always_comb begin
        s2_adv = !s2_valid_q | bus.out_ready;
        s1_adv = !s1_valid_q | s2_adv;

        in_inx = bus.guard | bus.round_bit | bus.sticky;
        in_rm  = decode_rm(bus.rm);

        case (in_rm)
            RM_RTZ:  in_round_up = 1'b0;
            RM_RDN:  in_round_up = bus.sign_in & in_inx;
            RM_RUP:  in_round_up = !bus.sign_in & in_inx;
            RM_RMM:  in_round_up = bus.guard;
            default: in_round_up = bus.guard & (bus.round_bit | bus.sticky | bus.mant_in[0]);
        endcase

        s1_valid_d    = s1_valid_q;
        s1_sign_d     = s1_sign_q;
        s1_mant_d     = s1_mant_q;
        s1_exp_d      = s1_exp_q;
        s1_rm_d       = s1_rm_q;
        s1_round_up_d = s1_round_up_q;
        s1_inx_d      = s1_inx_q;

        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_d     = bus.sign_in;
                s1_mant_d     = bus.mant_in;
                s1_exp_d      = bus.exp_in;
                s1_rm_d       = in_rm;
                s1_round_up_d = in_round_up;
                s1_inx_d      = in_inx;
            end
        end
    end

    fp_round_core #(
        .M (M),
        .E (E)
    ) u_core (
        .sign     (s1_sign_q),
        .mant     (s1_mant_q),
        .exp      (s1_exp_q),
        .round_up (s1_round_up_q),
        .inx      (s1_inx_q),
        .rm       (s1_rm_q),
        .result   (core_result),
        .flags    (core_flags)
    );

    // Stage 2: capture the packed result; holds while the consumer stalls.
    always_comb begin
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        flags_d    = flags_q;

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = core_result;
                flags_d  = core_flags;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples the
    // pre-edge value of its neighbours, independent of the order the blocks execute in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_mant_q     <= '0;
            s1_exp_q      <= '0;
            s1_rm_q       <= RM_RNE;
            s1_round_up_q <= 1'b0;
            s1_inx_q      <= 1'b0;
            s2_valid_q    <= 1'b0;
            result_q      <= '0;
            flags_q       <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_sign_q     <= s1_sign_d;
            s1_mant_q     <= s1_mant_d;
            s1_exp_q      <= s1_exp_d;
            s1_rm_q       <= s1_rm_d;
            s1_round_up_q <= s1_round_up_d;
            s1_inx_q      <= s1_inx_d;
            s2_valid_q    <= s2_valid_d;
            result_q      <= result_d;
            flags_q       <= flags_d;
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.result    = result_q;
    assign bus.of_flag   = flags_q.of;
    assign bus.uf_flag   = flags_q.uf;
    assign bus.nx_flag   = flags_q.nx;

`ifdef FP_ROUND_ACCUM_FLAGS_EN
    logic [2:0] fflags_acc_q, fflags_acc_d;

    // Clear drops history first, so a coinciding handshake leaves only its own flags.
    always_comb begin
        fflags_acc_d = flags_clr ? 3'b000 : fflags_acc_q;
        if (s2_valid_q && bus.out_ready) begin
            fflags_acc_d = fflags_acc_d | flags_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fflags_acc_q <= 3'b000;
        end else begin
            fflags_acc_q <= fflags_acc_d;
        end
    end

    assign fflags_acc = fflags_acc_q;
`endif

endmodule

// File: tb/tb_fp_round_pipe.sv
// Scoreboard bench for fp_round_pipe (M=23, E=8): directed vectors push expectations,
// an independent monitor pops and compares on every output handshake.
module tb_fp_round_pipe;

    typedef struct {
        logic [31:0] res;
        logic        of;
        logic        uf;
        logic        nx;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    fp_round_pipe_if #(.M(23), .E(8)) bus ();

`ifdef FP_ROUND_ACCUM_FLAGS_EN
    logic       flags_clr;
    logic [2:0] fflags_acc;
`endif

    fp_round_pipe #(
        .M (23),
        .E (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FP_ROUND_ACCUM_FLAGS_EN
        ,
        .flags_clr  (flags_clr),
        .fflags_acc (fflags_acc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send(input string name, input logic sgn, input logic [23:0] mant,
                        input logic [8:0] ex, input logic g, input logic r, input logic s,
                        input logic [2:0] rm, input logic [31:0] res,
                        input logic of, input logic uf, input logic nx);
        exp_t e;
        bit   done;
        bus.sign_in   = sgn;
        bus.mant_in   = mant;
        bus.exp_in    = ex;
        bus.guard     = g;
        bus.round_bit = r;
        bus.sticky    = s;
        bus.rm        = rm;
        bus.in_valid  = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            if (bus.in_ready) begin
                e.res = res; e.of = of; e.uf = uf; e.nx = nx; e.name = name;
                sb_q.push_back(e);
                done = 1'b1;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!done) check({name, "_accept_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        check({name, "_drained"}, 64'(sb_q.size()), 64'd0);
        @(negedge clk);
    endtask

    // Monitor: compares whenever the output handshake is about to complete.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", {29'd0, bus.result, bus.of_flag, bus.uf_flag, bus.nx_flag}, 64'd0);
                    if (bus.result == 32'd0) check("unexpected_output_valid", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check(e.name, {29'd0, bus.result, bus.of_flag, bus.uf_flag, bus.nx_flag},
                          {29'd0, e.res, e.of, e.uf, e.nx});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.sign_in = 1'b0; bus.mant_in = '0; bus.exp_in = '0;
        bus.guard = 1'b0; bus.round_bit = 1'b0; bus.sticky = 1'b0; bus.rm = 3'd0;
        bus.out_ready = 1'b1;
`ifdef FP_ROUND_ACCUM_FLAGS_EN
        flags_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_result", 64'(bus.result), 64'd0);
        check("reset_flags", 64'({bus.of_flag, bus.uf_flag, bus.nx_flag}), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef FP_ROUND_ACCUM_FLAGS_EN
        check("reset_acc", 64'(fflags_acc), 64'd0);
`endif
        @(negedge clk);

        // Directed vectors: name, sign, mant, exp, g, r, s, rm, result, of, uf, nx
        send("rne_tie_odd",   1'b0, 24'h800001, 9'h07F, 1, 0, 0, 3'd0, 32'h3F800002, 0, 0, 1);
        send("rne_tie_even",  1'b0, 24'h800000, 9'h07F, 1, 0, 0, 3'd0, 32'h3F800000, 0, 0, 1);
        send("rne_carry",     1'b0, 24'hFFFFFF, 9'h07F, 1, 1, 0, 3'd0, 32'h40000000, 0, 0, 1);
        send("ovf_rne",       1'b0, 24'hFFFFFF, 9'h0FE, 1, 0, 0, 3'd0, 32'h7F800000, 1, 0, 1);
        send("ovf_rtz",       1'b0, 24'hFFFFFF, 9'h0FE, 1, 0, 0, 3'd1, 32'h7F7FFFFF, 0, 0, 1);
        send("ovf_rdn_neg",   1'b1, 24'hFFFFFF, 9'h0FE, 1, 0, 0, 3'd2, 32'hFF800000, 1, 0, 1);
        send("sub_promote",   1'b0, 24'h7FFFFF, 9'h000, 1, 1, 0, 3'd0, 32'h00800000, 0, 1, 1);
        send("sub_rtz",       1'b0, 24'h7FFFFF, 9'h000, 1, 1, 0, 3'd1, 32'h007FFFFF, 0, 1, 1);
        send("neg_zero",      1'b1, 24'h000000, 9'h000, 0, 0, 0, 3'd0, 32'h80000000, 0, 0, 0);
        send("rup_sticky",    1'b0, 24'h800000, 9'h07F, 0, 0, 1, 3'd3, 32'h3F800001, 0, 0, 1);
        send("rmm_tie",       1'b0, 24'h800000, 9'h07F, 1, 0, 0, 3'd4, 32'h3F800001, 0, 0, 1);
        send("rm5_as_rne",    1'b0, 24'h800000, 9'h07F, 1, 0, 0, 3'd5, 32'h3F800000, 0, 0, 1);
        send("exact",         1'b0, 24'h800000, 9'h07F, 0, 0, 0, 3'd0, 32'h3F800000, 0, 0, 0);
        send("ovf_rup_neg",   1'b1, 24'h800000, 9'h0FF, 0, 0, 0, 3'd3, 32'hFF7FFFFF, 1, 0, 1);
        send("ovf_rdn_pos",   1'b0, 24'h800000, 9'h0FF, 0, 0, 0, 3'd2, 32'h7F7FFFFF, 1, 0, 1);
        send("ovf_rmm_neg",   1'b1, 24'h800000, 9'h0FF, 0, 0, 0, 3'd4, 32'hFF800000, 1, 0, 1);
        wait_drain("directed");

`ifdef FP_ROUND_ACCUM_FLAGS_EN
        check("acc_sticky", 64'(fflags_acc), 64'd7);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        #1;
        check("acc_cleared", 64'(fflags_acc), 64'd0);
        @(negedge clk);
`endif

        // Backpressure: two ops fill the pipe, then upstream must stall while output holds.
        bus.out_ready = 1'b0;
        send("bp0", 1'b0, 24'h800000, 9'h07F, 0, 0, 0, 3'd0, 32'h3F800000, 0, 0, 0);
        send("bp1", 1'b0, 24'h800001, 9'h07F, 0, 0, 0, 3'd0, 32'h3F800001, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            check("bp_result_hold", {31'd0, bus.out_valid, bus.result}, {31'd0, 1'b1, 32'h3F800000});
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        send("bp2", 1'b0, 24'h800002, 9'h07F, 0, 0, 0, 3'd0, 32'h3F800002, 0, 0, 0);
        send("bp3", 1'b0, 24'h800003, 9'h07F, 0, 0, 0, 3'd0, 32'h3F800003, 0, 0, 0);
        wait_drain("backpressure");

        // Reset with two ops in flight: both are discarded, nothing emerges afterwards.
        bus.out_ready = 1'b0;
        send("rst_a", 1'b0, 24'h800004, 9'h07F, 1, 0, 0, 3'd0, 32'h3F800004, 0, 0, 1);
        send("rst_b", 1'b0, 24'h800005, 9'h07F, 1, 0, 0, 3'd0, 32'h3F800006, 0, 0, 1);
        #1;
        check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef FP_ROUND_ACCUM_FLAGS_EN
        check("post_rst_acc", 64'(fflags_acc), 64'd0);
`endif
        repeat (6) @(negedge clk);
        #1;
        check("post_rst_no_output", 64'(bus.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_round_pipe.md
Name: fp_round_pipe

Overview:
Parametrised, pipelined IEEE-754 rounding and packing stage for the CUDA-core FPU. It takes a normalised or subnormal significand with guard/round/sticky bits, applies one of five rounding modes per operation, and handles carry renormalisation, overflow saturation and subnormal promotion. It emits a packed {sign, exp, frac} word plus exception flags. Sits after the add/mul/FMA normaliser and before writeback; valid/ready handshake on both sides.

Parameters:
M, 23, stored fraction width (hidden bit excluded)
E, 8, exponent field width
W, 1+E+M (derived localparam), packed result width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  input operation valid
in_ready  out  1  block can accept input this cycle
sign_in  in  1  result sign
mant_in  in  M+1  significand, bit M = hidden bit (0 when subnormal)
exp_in  in  E+1  biased exponent, extra MSB for pre-round overflow
guard  in  1  first bit below LSB
round_bit  in  1  second bit below LSB
sticky  in  1  OR of all remaining bits
rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  W  packed {sign, exp[E-1:0], frac[M-1:0]}
of_flag  out  1  overflow
uf_flag  out  1  underflow
nx_flag  out  1  inexact

Behaviour:
- Reset: all stage valids, out_valid, result and flags = 0; in_ready = 1 once rst deasserts. Reset mid-operation discards in-flight ops, with no partial output.
- Pipeline: 2 registered stages, latency 2 cycles, throughput 1/cycle.
- Stage S1: register inputs plus the round_up decision.
- Stage S2: increment, renormalise and pack.
- Handshake: s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv. Transfer occurs on valid & ready.
- While out_valid & !out_ready, result and flags hold stable. No drop and no duplication; ordering is preserved.
- Inexact: inx = guard | round_bit | sticky.
- round_up by mode:
  - RNE: guard & (round_bit | sticky | mant_in[0])
  - RTZ: 0
  - RDN: sign & inx
  - RUP: !sign & inx
  - RMM: guard
  - rm 5..7 are treated as RNE.
- Increment is performed at M+2 bits. On carry-out (bit M+1): shift right 1, exp+1, and frac becomes 0.
- Subnormal promotion: exp_in==0 and the rounded bit M becomes 1 → exp = 1.
- Overflow when final exp >= 2^E-1: of=1, nx=1. Result depends on mode:
  - RNE/RMM: ±inf
  - RTZ: ±max-finite
  - RDN: -inf if sign, else +max-finite
  - RUP: +inf if !sign, else -max-finite
- Underflow: uf = (exp_in==0) & inx, i.e. tininess is detected before rounding. This holds even when the result promotes to exp 1.
- Zero: mant_in==0 with exp_in==0 and !inx gives a signed zero with no flags.
- nx_flag = inx | of.

Optional Feature:
FP_ROUND_ACCUM_FLAGS_EN
- When defined, adds ports flags_clr (in, 1) and fflags_acc (out, 3 = {of, uf, nx}).
- fflags_acc is a sticky register that ORs in the flags of each result on its output handshake. flags_clr zeroes it next cycle.
- When clear and a handshake coincide, the clear wins, then the new flags are ORed in, so the register ends with only the current result's flags.
- Reset value of fflags_acc is 0.
- When the macro is undefined, these ports and the register do not exist; per-result flags are unchanged.

Decomposition:
- Package fp_round_pkg holds:
  - rm_e enum (RNE, RTZ, RDN, RUP, RMM)
  - flag struct {of, uf, nx}
  - functions for max-finite and inf encodings per (M, E)
- Natural sub-module: fp_round_core, the combinational S2 increment/renormalise/overflow/pack logic, reused by the FMA path.

Test Plan:
- RNE tie to even (M=23, E=8): mant_in=0x800001, exp_in=0x07F, g=1 r=0 s=0 → result 0x3F800002, nx=1. Same with mant_in=0x800000 → 0x3F800000, nx=1.
- Carry: mant_in=0xFFFFFF, exp_in=0x07F, g=1 r=1, RNE → 0x40000000, nx=1, of=0.
- Overflow: exp_in=0x0FE, mant_in=0xFFFFFF, g=1, sign=0. RNE → 0x7F800000 with of=1, nx=1. RTZ → 0x7F7FFFFF (max-finite, RTZ rounds down, not from of) with of=0, nx=1. RDN with sign=1 → 0xFF800000 with of=1.
- Subnormal: exp_in=0, mant_in=0x7FFFFF, g=1 r=1, RNE → 0x00800000, uf=1, nx=1. Same with RTZ → 0x007FFFFF, uf=1.
- Backpressure: hold out_ready=0 for 4 cycles and present 4 back-to-back ops. in_ready falls after 2 accepted; after release, results emerge in order, one per cycle, all 4 present.
- Reset mid-flight: assert rst with 2 ops in flight → out_valid=0 at once, with no output after release. With FP_ROUND_ACCUM_FLAGS_EN, fflags_acc=0 after reset.
